ultratank_input_conditioner: RTL and testbench

- Sits between the hps_io/DB9/DB15 joystick merge and the ultra_tank core inputs.
- Synchronises and debounces each player's 8-way joystick and buttons, then encodes direction into the two-lever tread signals (W/X for player 1, Y/Z for player 2).
- Stretches each coin press into a fixed-width pulse and drives all core inputs with the polarity the core expects.

---
 rtl/ultratank_input_conditioner.sv | 147 ++++++++++++++
 tb/tb_ultratank_input_conditioner.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultratank_input_conditioner.sv
// Joystick/button conditioner for the ultra_tank core: sync, debounce, tread-lever
// encoding and coin pulse stretching, with active-low core polarities.
module ultratank_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 12000,
    parameter int unsigned COIN_PULSE_CYCLES = 600000,
    parameter int unsigned CNT_W             = 20
) (
    input  logic       clk_sys,
    input  logic       Reset_n,
    input  logic       inhibit,
    input  logic [7:0] joy1,
    input  logic [7:0] joy2,
    output logic       JoyW_Fw_n,
    output logic       JoyW_Bk_n,
    output logic       JoyX_Fw_n,
    output logic       JoyX_Bk_n,
    output logic       JoyY_Fw_n,
    output logic       JoyY_Bk_n,
    output logic       JoyZ_Fw_n,
    output logic       JoyZ_Bk_n,
    output logic       FireA,
    output logic       FireB,
    output logic       Start1_n,
    output logic       Start2_n,
    output logic       Coin1_n,
    output logic       Coin2_n
);

    localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CoinLast = CNT_W'(COIN_PULSE_CYCLES - 1);

    typedef enum logic {StIdle, StPulse} coin_st_e;

    logic [15:0]      sync1_q, sync2_q, deb_q, deb_d, accept;
    logic [CNT_W-1:0] cnt_q [16];
    logic [CNT_W-1:0] cnt_d [16];
    logic [1:0]       rise_q;
    logic [3:0]       lev1_n_q, lev2_n_q;
    logic [1:0]       fire_q, start_n_q;

    // Returns {lever1 Fw, lever1 Bk, lever2 Fw, lever2 Bk}, active-high, from {u,d,l,r}.
    function automatic logic [3:0] tread(input logic [3:0] udlr);
        case (udlr)
            4'b1000: tread = 4'b1010;
            4'b1010: tread = 4'b0010;
            4'b1001: tread = 4'b1000;
            4'b0001: tread = 4'b1001;
            4'b0101: tread = 4'b0100;
            4'b0100: tread = 4'b0101;
            4'b0110: tread = 4'b0001;
            4'b0010: tread = 4'b0110;
            default: tread = 4'b0000;
        endcase
    endfunction

    // A bit is accepted on the cycle its counter would reach DEBOUNCE_CYCLES.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            accept[i] = (sync2_q[i] != deb_q[i]) && (cnt_q[i] == DebLast);
            deb_d[i]  = accept[i] ? sync2_q[i] : deb_q[i];
            cnt_d[i]  = ((sync2_q[i] == deb_q[i]) || accept[i]) ? '0 : cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            rise_q  <= '0;
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= {joy2, joy1};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
            // Coin edges accepted during inhibit are dropped here.
            rise_q  <= {accept[15] & sync2_q[15], accept[7] & sync2_q[7]} & {2{~inhibit}};
        end
    end

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            lev1_n_q  <= 4'hF;
            lev2_n_q  <= 4'hF;
            fire_q    <= 2'b00;
            start_n_q <= 2'b11;
        end else if (inhibit) begin
            lev1_n_q  <= 4'hF;
            lev2_n_q  <= 4'hF;
            fire_q    <= 2'b00;
            start_n_q <= 2'b11;
        end else begin
            lev1_n_q  <= ~tread(deb_q[3:0]);
            lev2_n_q  <= ~tread(deb_q[11:8]);
            fire_q    <= {deb_q[12], deb_q[4]};
            start_n_q <= {~(deb_q[6] | deb_q[14]), ~(deb_q[5] | deb_q[13])};
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_coin
        coin_st_e         st_q;
        logic [CNT_W-1:0] pcnt_q;
        logic             coin_n_q;

        always_ff @(posedge clk_sys or negedge Reset_n) begin
            if (!Reset_n) begin
                st_q     <= StIdle;
                pcnt_q   <= '0;
                coin_n_q <= 1'b1;
            end else if (inhibit) begin
                st_q     <= StIdle;
                pcnt_q   <= '0;
                coin_n_q <= 1'b1;
            end else begin
                case (st_q)
                    StIdle: begin
                        if (rise_q[p]) begin
                            st_q     <= StPulse;
                            pcnt_q   <= CoinLast;
                            coin_n_q <= 1'b0;
                        end
                    end
                    StPulse: begin
                        if (pcnt_q == '0) begin
                            st_q     <= StIdle;
                            coin_n_q <= 1'b1;
                        end else begin
                            pcnt_q <= pcnt_q - 1'b1;
                        end
                    end
                    default: st_q <= StIdle;
                endcase
            end
        end
    end

    assign {JoyW_Fw_n, JoyW_Bk_n, JoyX_Fw_n, JoyX_Bk_n} = lev1_n_q;
    assign {JoyY_Fw_n, JoyY_Bk_n, JoyZ_Fw_n, JoyZ_Bk_n} = lev2_n_q;
    assign FireA    = fire_q[0];
    assign FireB    = fire_q[1];
    assign Start1_n = start_n_q[0];
    assign Start2_n = start_n_q[1];
    assign Coin1_n  = g_coin[0].coin_n_q;
    assign Coin2_n  = g_coin[1].coin_n_q;

endmodule

// File: tb/tb_ultratank_input_conditioner.sv
// Bench for ultratank_input_conditioner: direction table, hand-written corner sequences
// and randomized traffic compared against a windowed behavioural model.
module tb_ultratank_input_conditioner;

    localparam int D = 4;
    localparam int P = 10;
    localparam logic [13:0] INACT = 14'b1111_1111_00_11_11;

    logic       clk_sys = 1'b0;
    logic       Reset_n = 1'b0;
    logic       inhibit = 1'b0;
    logic [7:0] joy1 = 8'h00;
    logic [7:0] joy2 = 8'h00;
    logic JoyW_Fw_n, JoyW_Bk_n, JoyX_Fw_n, JoyX_Bk_n;
    logic JoyY_Fw_n, JoyY_Bk_n, JoyZ_Fw_n, JoyZ_Bk_n;
    logic FireA, FireB, Start1_n, Start2_n, Coin1_n, Coin2_n;

    ultratank_input_conditioner #(
        .DEBOUNCE_CYCLES  (D),
        .COIN_PULSE_CYCLES(P),
        .CNT_W            (20)
    ) dut (
        .clk_sys  (clk_sys),
        .Reset_n  (Reset_n),
        .inhibit  (inhibit),
        .joy1     (joy1),
        .joy2     (joy2),
        .JoyW_Fw_n(JoyW_Fw_n),
        .JoyW_Bk_n(JoyW_Bk_n),
        .JoyX_Fw_n(JoyX_Fw_n),
        .JoyX_Bk_n(JoyX_Bk_n),
        .JoyY_Fw_n(JoyY_Fw_n),
        .JoyY_Bk_n(JoyY_Bk_n),
        .JoyZ_Fw_n(JoyZ_Fw_n),
        .JoyZ_Bk_n(JoyZ_Bk_n),
        .FireA    (FireA),
        .FireB    (FireB),
        .Start1_n (Start1_n),
        .Start2_n (Start2_n),
        .Coin1_n  (Coin1_n),
        .Coin2_n  (Coin2_n)
    );

    always #5 clk_sys = ~clk_sys;

    logic [13:0] dut_outs;
    assign dut_outs = {JoyW_Fw_n, JoyW_Bk_n, JoyX_Fw_n, JoyX_Bk_n,
                       JoyY_Fw_n, JoyY_Bk_n, JoyZ_Fw_n, JoyZ_Bk_n,
                       FireA, FireB, Start1_n, Start2_n, Coin1_n, Coin2_n};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sync = raw two edges ago; a bit flips once its last D synced
    // samples all disagree with the accepted value. Coin pulses counted in remaining cycles.
    logic [15:0] m_raw_hist[$];
    logic [15:0] m_sync_hist[$];
    logic [15:0] m_deb;
    logic [13:0] m_out;
    int          m_left[2];
    logic [1:0]  m_rise;

    function automatic logic [3:0] tread_ref(input logic [3:0] udlr);
        logic u, d, l, r;
        {u, d, l, r} = udlr;
        if (u & !d & !l & !r) return 4'b1010;
        if (u & !d & l & !r)  return 4'b0010;
        if (u & !d & !l & r)  return 4'b1000;
        if (!u & !d & !l & r) return 4'b1001;
        if (!u & d & !l & r)  return 4'b0100;
        if (!u & d & !l & !r) return 4'b0101;
        if (!u & d & l & !r)  return 4'b0001;
        if (!u & !d & l & !r) return 4'b0110;
        return 4'b0000;
    endfunction

    task automatic m_reset();
        m_raw_hist.delete();
        m_sync_hist.delete();
        m_deb  = '0;
        m_out  = INACT;
        m_left = '{0, 0};
        m_rise = '0;
    endtask

    task automatic model_edge(input logic [15:0] raw, input logic inh);
        logic [15:0] sync, new_deb;
        logic [1:0]  coin_n;
        for (int p = 0; p < 2; p++) begin
            if (inh) m_left[p] = 0;
            else if (m_left[p] > 0) m_left[p]--;
            else if (m_rise[p]) m_left[p] = P;
            coin_n[p] = (m_left[p] == 0);
        end
        if (inh) m_out = INACT;
        else m_out = {~tread_ref(m_deb[3:0]), ~tread_ref(m_deb[11:8]), m_deb[4], m_deb[12],
                      ~(m_deb[5] | m_deb[13]), ~(m_deb[6] | m_deb[14]), coin_n[0], coin_n[1]};
        sync = (m_raw_hist.size() >= 2) ? m_raw_hist[m_raw_hist.size() - 2] : 16'h0;
        m_raw_hist.push_back(raw);
        if (m_raw_hist.size() > 2) void'(m_raw_hist.pop_front());
        m_sync_hist.push_back(sync);
        if (m_sync_hist.size() > D) void'(m_sync_hist.pop_front());
        new_deb = m_deb;
        if (m_sync_hist.size() == D) begin
            for (int b = 0; b < 16; b++) begin
                bit all_diff = 1'b1;
                for (int k = 0; k < D; k++)
                    if (m_sync_hist[k][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) new_deb[b] = ~m_deb[b];
            end
        end
        m_rise[0] = ~m_deb[7] & new_deb[7] & ~inh;
        m_rise[1] = ~m_deb[15] & new_deb[15] & ~inh;
        m_deb = new_deb;
    endtask

    int   cl1, cf1, cl2;
    logic prev_c1 = 1'b1;

    task automatic clr_coin();
        cl1 = 0;
        cf1 = 0;
        cl2 = 0;
    endtask

    task automatic step();
        @(posedge clk_sys);
        if (Reset_n) model_edge({joy2, joy1}, inhibit);
        else m_reset();
        @(negedge clk_sys);
        check("model", 32'(dut_outs), 32'(m_out));
        if (!Coin1_n) cl1++;
        if (prev_c1 && !Coin1_n) cf1++;
        prev_c1 = Coin1_n;
        if (!Coin2_n) cl2++;
    endtask

    typedef struct {
        logic [7:0] joy;
        logic [3:0] lev_n;
    } dir_vec_t;

    dir_vec_t vecs[10];

    initial begin
        int t;
        vecs[0] = '{8'h08, 4'b0101};
        vecs[1] = '{8'h0A, 4'b1101};
        vecs[2] = '{8'h09, 4'b0111};
        vecs[3] = '{8'h01, 4'b0110};
        vecs[4] = '{8'h05, 4'b1011};
        vecs[5] = '{8'h04, 4'b1010};
        vecs[6] = '{8'h06, 4'b1110};
        vecs[7] = '{8'h02, 4'b1001};
        vecs[8] = '{8'h0C, 4'b1111};
        vecs[9] = '{8'h03, 4'b1111};
        m_reset();
        clr_coin();

        repeat (3) @(negedge clk_sys);
        check("reset_outs", 32'(dut_outs), 32'(INACT));
        Reset_n = 1'b1;
        repeat (10) step();
        check("idle_after_reset", 32'(dut_outs), 32'(INACT));

        for (int i = 0; i < 10; i++) begin
            joy1 = vecs[i].joy;
            repeat (6) step();
            check($sformatf("dir_early_%h", vecs[i].joy), 32'(dut_outs[13:10]), 32'hF);
            step();
            check($sformatf("dir_%h", vecs[i].joy), 32'(dut_outs[13:10]), 32'(vecs[i].lev_n));
            joy1 = 8'h00;
            repeat (10) step();
        end
        joy2 = 8'h02;
        repeat (7) step();
        check("dir_p2_left", 32'(dut_outs[9:6]), 32'b1001);
        joy2 = 8'h00;
        repeat (10) step();

        joy2 = 8'h10;
        repeat (3) step();
        joy2 = 8'h00;
        for (int i = 0; i < 12; i++) begin
            step();
            check("glitch_fireb", 32'(FireB), 32'd0);
        end
        joy2 = 8'h10;
        repeat (6) step();
        check("fireb_early", 32'(FireB), 32'd0);
        step();
        check("fireb_latency", 32'(FireB), 32'd1);
        repeat (5) step();
        joy2 = 8'h00;
        repeat (10) step();

        clr_coin();
        joy1 = 8'h80;
        repeat (100) step();
        joy1 = 8'h00;
        repeat (20) step();
        check("coin_width", 32'(cl1), 32'(P));
        check("coin_once", 32'(cf1), 32'd1);
        clr_coin();
        joy1 = 8'h80;
        repeat (30) step();
        joy1 = 8'h00;
        repeat (20) step();
        check("coin_second_width", 32'(cl1), 32'(P));
        check("coin_second_once", 32'(cf1), 32'd1);
        check("coin2_idle", 32'(cl2), 32'd0);

        clr_coin();
        joy1 = 8'h80;
        repeat (4) step();
        joy1 = 8'h00;
        repeat (4) step();
        joy1 = 8'h80;
        repeat (20) step();
        joy1 = 8'h00;
        repeat (20) step();
        check("retrig_width", 32'(cl1), 32'(P));
        check("retrig_once", 32'(cf1), 32'd1);

        joy1 = 8'h88;
        t = 0;
        while (Coin1_n && t < 30) begin
            step();
            t++;
        end
        check("inh_coin_started", 32'(Coin1_n), 32'd0);
        repeat (3) step();
        inhibit = 1'b1;
        step();
        check("inh_coin_abort", 32'(Coin1_n), 32'd1);
        check("inh_tread_off", 32'(dut_outs[13:10]), 32'hF);
        repeat (4) step();
        inhibit = 1'b0;
        step();
        check("inh_tread_resume", 32'(dut_outs[13:10]), 32'b0101);
        clr_coin();
        repeat (20) step();
        check("inh_no_coin", 32'(cl1), 32'd0);
        joy1 = 8'h00;
        repeat (12) step();

        joy1 = 8'h28;
        repeat (10) step();
        #2 Reset_n = 1'b0;
        #1 check("async_reset", 32'(dut_outs), 32'(INACT));
        m_reset();
        step();
        step();
        Reset_n = 1'b1;
        joy1 = 8'h00;
        repeat (10) step();
        check("post_reset_idle", 32'(dut_outs), 32'(INACT));

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) joy1 = 8'($urandom);
            if ($urandom_range(0, 9) == 0) joy2 = 8'($urandom);
            if ($urandom_range(0, 49) == 0) inhibit = ~inhibit;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
